dm_sysbus_access: RTL and testbench
===================================

# dm_sysbus_access

System Bus Access (SBA) engine of the debug module. It executes single-beat reads and writes on the system bus on behalf of the debugger, triggered by DMI writes and reads of the sbaddress0 and sbdata0 registers. It sits downstream of the DM CSR decoder, which supplies the sbcs fields and register strobes. It sits upstream of the SoC bus master port and returns read data and error codes back to the CSR block.

## Interface
Parameters:
- BusWidth, 32: system bus address/data width (32 or 64).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- dmactive_i  in  1  low = abort/clear (synchronous).
- sbaddress_i  in  BusWidth  new address value from the DMI.
- sbaddress_write_valid_i  in  1  one-cycle strobe: load address.
- sbreadonaddr_i  in  1  sbcs.sbreadonaddr.
- sbautoincrement_i  in  1  sbcs.sbautoincrement.
- sbaccess_i  in  3  sbcs.sbaccess (log2 bytes).
- sbreadondata_i  in  1  sbcs.sbreadondata.
- sbdata_i  in  BusWidth  write data.
- sbdata_read_valid_i  in  1  strobe: DMI read of sbdata0.
- sbdata_write_valid_i  in  1  strobe: DMI write of sbdata0.
- sbaddress_o  out  BusWidth  current address.
- sbdata_o  out  BusWidth  last read data, right-aligned.
- sbdata_valid_o  out  1  one-cycle pulse: sbdata_o updated.
- sbbusy_o  out  1  transaction in progress.
- sberror_valid_o  out  1  one-cycle pulse: sberror_o valid.
- sberror_o  out  3  error code.
- master_req_o, master_we_o  out  1  bus request, write enable.
- master_add_o, master_wdata_o  out  BusWidth  address, write data.
- master_be_o  out  BusWidth/8  byte enables.
- master_gnt_i, master_r_valid_i, master_r_err_i  in  1  grant, response valid, response error.
- master_r_rdata_i  in  BusWidth  read data.

## Operation
- FSM uses the shared enum sba_state_e: Idle, Read, Write, WaitRead, WaitWrite.
- Idle transitions, in priority order:
  - sbaddress_write_valid_i: load the address. If sbreadonaddr_i is set, go to Read.
  - sbdata_write_valid_i: go to Write, with sbdata_i latched.
  - sbdata_read_valid_i with sbreadondata_i set: go to Read.
- Strobes arriving outside Idle are ignored. The CSR block flags sbbusyerror.
- Checks on entry, replacing the transition (no bus request, stays Idle):
  - (1<<sbaccess_i) > BusWidth/8: sberror 4 (size).
  - address not aligned to 1<<sbaccess_i: sberror 3 (alignment).
  - In both cases sberror_valid_o pulses.
- Read/Write states:
  - master_req_o=1. On master_gnt_i, go to WaitRead/WaitWrite.
  - master_add_o = address.
  - master_be_o = ((1<<(1<<sbaccess))-1) << addr[lane bits].
  - master_wdata_o = the low 1<<sbaccess bytes of latched data, replicated across all lanes.
- Wait states:
  - On master_r_valid_i, return to Idle.
  - No error: for reads, sbdata_o = rdata >> (8*addr[lane bits]), zero-masked to the access size, and sbdata_valid_o pulses. Then, if sbautoincrement_i is set, address += 1<<sbaccess (wraps modulo 2^BusWidth).
  - master_r_err_i: sberror 2 (bad address). Pulse sberror_valid_o; no data update, no increment.
- sbbusy_o = (state != Idle).
- dmactive_i low:
  - Idle/Read/Write: go to Idle, clear address and sbdata_o. No request is issued in the following cycle.
  - Wait states: remain until master_r_valid_i to absorb the response, then go to Idle without data, error, or increment.

## Timing
- Reset values: state Idle, all outputs 0, internal address/data 0.
- Trigger strobe at cycle t: master_req_o high at t+1, sbbusy_o high at t+1.
- Request held stable (address, be, wdata, we) until grant. Grant in cycle g moves to Wait at g+1.
- master_r_valid_i may arrive at g+1 at earliest. master_r_valid_i at cycle r gives: sbdata_valid_o/sberror_valid_o pulse at r+1, updated address at r+1, sbbusy_o low at r+1.
- Best-case read: strobe t, req t+1 (grant same cycle), r_valid t+2, data t+3.
- Check-failure error pulse at t+1. sbbusy_o never rises.
- Async reset mid-transaction: immediate return to Idle. Outstanding bus responses after reset are not tracked.

## Structure
- Shared package dm additions:
  - localparams SbErrNone=0, SbErrTimeout=1, SbErrBadAddr=2, SbErrAlign=3, SbErrSize=4, SbErrOther=7.
  - sba_state_e and sbcs_t stay there.
- Single module, no sub-modules. Lane shift/mask logic is local combinational code.

## Test plan
- 32-bit read: sbaddress 0x1000_0004, sbreadonaddr=1, sbaccess=2; slave grants at once and returns 0xDEAD_BEEF -> req at t+1, be=4'hF, sbdata_o=0xDEAD_BEEF pulse at t+3.
- Byte write: address 0x103, sbaccess=0, sbdata 0x5A -> be=4'b1000, wdata=0x5A5A_5A5A. With autoincrement, sbaddress_o becomes 0x104 after response.
- Misaligned half-word read at 0x101 -> sberror 3 pulse at t+1, no master_req_o. sbaccess=3 on BusWidth 32 -> sberror 4.
- Bus error on read at 0x2000 with autoincrement -> sberror 2 pulse, address stays 0x2000, sbdata_o unchanged.
- Grant withheld 5 cycles -> request fields stable throughout. A sbdata_write_valid_i strobe during busy is ignored.
- dmactive_i drop in WaitRead; response arrives 3 cycles later -> no sbdata_valid_o, then Idle with address 0. Assert rst_ni mid-Write -> all outputs 0 immediately.

Source files
------------

// File: rtl/dm_sysbus_access_pkg.sv
// Shared debug-module types for the system bus access engine: FSM states,
// sbcs layout and sberror codes.
package dm_sysbus_access_pkg;

    localparam logic [2:0] SbErrNone    = 3'd0;
    localparam logic [2:0] SbErrTimeout = 3'd1;
    localparam logic [2:0] SbErrBadAddr = 3'd2;
    localparam logic [2:0] SbErrAlign   = 3'd3;
    localparam logic [2:0] SbErrSize    = 3'd4;
    localparam logic [2:0] SbErrOther   = 3'd7;

    typedef enum logic [2:0] {
        Idle,
        Read,
        Write,
        WaitRead,
        WaitWrite
    } sba_state_e;

    typedef struct packed {
        logic [2:0] sbversion;
        logic [5:0] zero0;
        logic       sbbusyerror;
        logic       sbbusy;
        logic       sbreadonaddr;
        logic [2:0] sbaccess;
        logic       sbautoincrement;
        logic       sbreadondata;
        logic [2:0] sberror;
        logic [6:0] sbasize;
        logic       sbaccess128;
        logic       sbaccess64;
        logic       sbaccess32;
        logic       sbaccess16;
        logic       sbaccess8;
    } sbcs_t;

endpackage

// File: rtl/dm_sysbus_access_if.sv
// SBA bus master port bundle; the engine keeps flat ports and integrators
// bind them through this interface.
interface dm_sysbus_access_if #(
    parameter int BusWidth = 32
);
    logic                  req;
    logic                  we;
    logic [BusWidth-1:0]   add;
    logic [BusWidth-1:0]   wdata;
    logic [BusWidth/8-1:0] be;
    logic                  gnt;
    logic                  r_valid;
    logic                  r_err;
    logic [BusWidth-1:0]   r_rdata;

    modport master (
        output req, we, add, wdata, be,
        input  gnt, r_valid, r_err, r_rdata
    );

    modport slave (
        input  req, we, add, wdata, be,
        output gnt, r_valid, r_err, r_rdata
    );
endinterface

// File: rtl/dm_sysbus_access.sv
// System bus access engine: single-beat reads/writes on behalf of the
// debugger, with size/alignment checks, lane steering and autoincrement.
module dm_sysbus_access
    import dm_sysbus_access_pkg::*;
#(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o,
    output logic                  master_req_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i
);

    localparam int NumBytes = BusWidth / 8;
    localparam int LaneBits = $clog2(NumBytes);

    sba_state_e r_state, w_state_next;

    logic [BusWidth-1:0] r_addr, r_wdata, r_rdata;
    logic                r_abort, r_data_valid, r_err_valid;
    logic [2:0]          r_err;

    logic                w_trig_read, w_trig_write, w_idle_go, w_in_wait;
    logic                w_size_err, w_align_err;
    logic [2:0]          w_err_code;
    logic [7:0]          w_access_bytes;
    logic [LaneBits-1:0] w_lane, w_byte_mask;
    logic [BusWidth-1:0] w_check_addr, w_rshift, w_rdata_aligned;
    logic [NumBytes-1:0] w_be_base;

    assign w_access_bytes = 8'd1 << sbaccess_i;
    assign w_byte_mask    = LaneBits'(w_access_bytes - 8'd1);
    assign w_lane         = r_addr[LaneBits-1:0];
    assign w_in_wait      = (r_state == WaitRead) || (r_state == WaitWrite);

    // A fresh address takes part in the checks in the same cycle it is written.
    assign w_check_addr = sbaddress_write_valid_i ? sbaddress_i : r_addr;
    assign w_size_err   = sbaccess_i > 3'(LaneBits);
    assign w_align_err  = |(w_check_addr & (BusWidth'(w_access_bytes) - 1'b1));
    assign w_err_code   = w_size_err  ? SbErrSize  :
                          w_align_err ? SbErrAlign : SbErrNone;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_trig_read  = 1'b0;
        w_trig_write = 1'b0;
        if (sbaddress_write_valid_i)                          w_trig_read  = sbreadonaddr_i;
        else if (sbdata_write_valid_i)                        w_trig_write = 1'b1;
        else if (sbdata_read_valid_i && sbreadondata_i)       w_trig_read  = 1'b1;
    end

    assign w_idle_go = (r_state == Idle) && dmactive_i && (w_trig_read || w_trig_write);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_ni) r_state <= Idle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            Idle:      if (w_idle_go && (w_err_code == SbErrNone))
                           w_state_next = w_trig_write ? Write : Read;
            Read:      if (!dmactive_i)       w_state_next = Idle;
                       else if (master_gnt_i) w_state_next = WaitRead;
            Write:     if (!dmactive_i)       w_state_next = Idle;
                       else if (master_gnt_i) w_state_next = WaitWrite;
            WaitRead,
            WaitWrite: if (master_r_valid_i)  w_state_next = Idle;
            default:   w_state_next = Idle;
        endcase
    end

    // Request is gated by dmactive so an abort never leaves a grant unanswered.
    always_comb begin
        master_req_o = ((r_state == Read) || (r_state == Write)) && dmactive_i;
        master_we_o  = (r_state == Write);
        sbbusy_o     = (r_state != Idle);
    end

    always_comb begin
        master_wdata_o  = '0;
        w_rdata_aligned = '0;
        w_be_base       = '0;
        w_rshift        = master_r_rdata_i >> {w_lane, 3'b000};
        for (int i = 0; i < NumBytes; i++) begin
            w_be_base[i]                 = i < int'(w_access_bytes);
            master_wdata_o[8*i +: 8]     = r_wdata[{LaneBits'(i) & w_byte_mask, 3'b000} +: 8];
            w_rdata_aligned[8*i +: 8]    = w_be_base[i] ? w_rshift[8*i +: 8] : 8'h00;
        end
        master_be_o = ((r_state == Read) || (r_state == Write)) ? (w_be_base << w_lane) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_abort      <= 1'b0;
            r_data_valid <= 1'b0;
            r_err_valid  <= 1'b0;
            r_err        <= SbErrNone;
        end else begin
            r_data_valid <= 1'b0;
            r_err_valid  <= 1'b0;
            r_abort      <= w_in_wait && !master_r_valid_i && (r_abort || !dmactive_i);

            if (!dmactive_i) begin
                r_addr  <= '0;
                r_rdata <= '0;
            end else if (r_state == Idle) begin
                if (sbaddress_write_valid_i)   r_addr  <= sbaddress_i;
                else if (sbdata_write_valid_i) r_wdata <= sbdata_i;
                if (w_idle_go && (w_err_code != SbErrNone)) begin
                    r_err_valid <= 1'b1;
                    r_err       <= w_err_code;
                end
            end else if (w_in_wait && master_r_valid_i && !r_abort) begin
                if (master_r_err_i) begin
                    r_err_valid <= 1'b1;
                    r_err       <= SbErrBadAddr;
                end else begin
                    if (r_state == WaitRead) begin
                        r_rdata      <= w_rdata_aligned;
                        r_data_valid <= 1'b1;
                    end
                    if (sbautoincrement_i) r_addr <= r_addr + BusWidth'(w_access_bytes);
                end
            end
        end
    end

    assign master_add_o    = r_addr;
    assign sbaddress_o     = r_addr;
    assign sbdata_o        = r_rdata;
    assign sbdata_valid_o  = r_data_valid;
    assign sberror_valid_o = r_err_valid;
    assign sberror_o       = r_err;

endmodule

// File: tb/tb_dm_sysbus_access.sv
// Bench for dm_sysbus_access: directed SBA transactions, scoreboarded read
// data and error codes, plus cycle-accurate request/timing checks.
module tb_dm_sysbus_access;
    localparam int BW = 32;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic          dmactive, addr_wv, readonaddr, autoinc, readondata, data_rv, data_wv;
    logic [2:0]    access;
    logic [BW-1:0] sbaddress_in, sbdata_in;
    logic [BW-1:0] sbaddress_out, sbdata_out;
    logic          sbdata_valid, sbbusy, sberr_valid;
    logic [2:0]    sberr;

    dm_sysbus_access_if #(.BusWidth(BW)) bus ();

    dm_sysbus_access #(.BusWidth(BW)) dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .dmactive_i              (dmactive),
        .sbaddress_i             (sbaddress_in),
        .sbaddress_write_valid_i (addr_wv),
        .sbreadonaddr_i          (readonaddr),
        .sbautoincrement_i       (autoinc),
        .sbaccess_i              (access),
        .sbreadondata_i          (readondata),
        .sbdata_i                (sbdata_in),
        .sbdata_read_valid_i     (data_rv),
        .sbdata_write_valid_i    (data_wv),
        .sbaddress_o             (sbaddress_out),
        .sbdata_o                (sbdata_out),
        .sbdata_valid_o          (sbdata_valid),
        .sbbusy_o                (sbbusy),
        .sberror_valid_o         (sberr_valid),
        .sberror_o               (sberr),
        .master_req_o            (bus.req),
        .master_we_o             (bus.we),
        .master_add_o            (bus.add),
        .master_wdata_o          (bus.wdata),
        .master_be_o             (bus.be),
        .master_gnt_i            (bus.gnt),
        .master_r_valid_i        (bus.r_valid),
        .master_r_err_i          (bus.r_err),
        .master_r_rdata_i        (bus.r_rdata)
    );

    int total = 0;
    int bad   = 0;
    logic [BW-1:0] exp_data_q[$];
    logic [2:0]    exp_err_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe_addr(input logic [BW-1:0] a);
        sbaddress_in = a; addr_wv = 1'b1; tick(); addr_wv = 1'b0;
    endtask

    task automatic strobe_wdata(input logic [BW-1:0] d);
        sbdata_in = d; data_wv = 1'b1; tick(); data_wv = 1'b0;
    endtask

    task automatic strobe_rdata();
        data_rv = 1'b1; tick(); data_rv = 1'b0;
    endtask

    // Slave: wait (bounded) for a request, withhold grant, then respond.
    task automatic serve(input logic [BW-1:0] rdata, input logic err, input int hold);
        int n = 0;
        while (!bus.req && n < 20) begin tick(); n++; end
        if (!bus.req) begin
            check("req_timeout", {63'd0, bus.req}, 64'd1);
            return;
        end
        repeat (hold) tick();
        bus.gnt = 1'b1; tick(); bus.gnt = 1'b0;
        bus.r_valid = 1'b1; bus.r_rdata = rdata; bus.r_err = err;
        tick();
        bus.r_valid = 1'b0; bus.r_err = 1'b0;
    endtask

    // Scoreboard side: every pulse must match the oldest expected result.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (sbdata_valid) begin
                if (exp_data_q.size() == 0) check("data_unexpected", {63'd0, sbdata_valid}, 64'd0);
                else                        check("sbdata", sbdata_out, exp_data_q.pop_front());
            end
            if (sberr_valid) begin
                if (exp_err_q.size() == 0) check("err_unexpected", {63'd0, sberr_valid}, 64'd0);
                else                       check("sberror", sberr, exp_err_q.pop_front());
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; dmactive = 1'b1; addr_wv = 0; readonaddr = 0; autoinc = 0;
        readondata = 0; data_rv = 0; data_wv = 0; access = 3'd2;
        sbaddress_in = '0; sbdata_in = '0;
        bus.gnt = 0; bus.r_valid = 0; bus.r_err = 0; bus.r_rdata = '0;
        repeat (3) tick();
        check("rst_addr",  sbaddress_out, 0);
        check("rst_data",  sbdata_out, 0);
        check("rst_busy",  sbbusy, 0);
        check("rst_req",   bus.req, 0);
        check("rst_be",    bus.be, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_errv",  sberr_valid, 0);
        rst_ni = 1'b1;
        tick();

        // Best-case 32-bit read
        readonaddr = 1'b1;
        exp_data_q.push_back(32'hDEAD_BEEF);
        strobe_addr(32'h1000_0004);
        check("t1_req",  bus.req, 1);
        check("t1_busy", sbbusy, 1);
        check("t1_be",   bus.be, 4'hF);
        check("t1_add",  bus.add, 32'h1000_0004);
        check("t1_we",   bus.we, 0);
        bus.gnt = 1'b1; tick(); bus.gnt = 1'b0;
        check("t1_wait_req", bus.req, 0);
        bus.r_valid = 1'b1; bus.r_rdata = 32'hDEAD_BEEF; tick(); bus.r_valid = 1'b0;
        check("t1_valid", sbdata_valid, 1);
        check("t1_idle",  sbbusy, 0);
        readonaddr = 1'b0;

        // Byte write with autoincrement
        access = 3'd0; autoinc = 1'b1;
        strobe_addr(32'h103);
        check("t2_addr", sbaddress_out, 32'h103);
        check("t2_noreq", sbbusy, 0);
        strobe_wdata(32'h5A);
        check("t2_we",    bus.we, 1);
        check("t2_be",    bus.be, 4'b1000);
        check("t2_wdata", bus.wdata, 32'h5A5A_5A5A);
        serve('0, 1'b0, 0);
        check("t2_inc", sbaddress_out, 32'h104);
        autoinc = 1'b0;

        // Check failures: misaligned half-word, oversize access
        access = 3'd1; readonaddr = 1'b1;
        exp_err_q.push_back(3'd3);
        strobe_addr(32'h101);
        check("t3_align_v", sberr_valid, 1);
        check("t3_align_req", bus.req, 0);
        check("t3_align_busy", sbbusy, 0);
        access = 3'd3;
        exp_err_q.push_back(3'd4);
        strobe_addr(32'h200);
        check("t3_size_v", sberr_valid, 1);
        check("t3_size_code", sberr, 4);
        tick();
        check("t3_busy", sbbusy, 0);

        // Bus error on read with autoincrement
        access = 3'd2; autoinc = 1'b1;
        exp_err_q.push_back(3'd2);
        strobe_addr(32'h2000);
        serve(32'h1111_1111, 1'b1, 0);
        check("t4_errv", sberr_valid, 1);
        check("t4_addr", sbaddress_out, 32'h2000);
        check("t4_data", sbdata_out, 32'hDEAD_BEEF);
        readonaddr = 1'b0;

        // Half-word read in upper lane, triggered by a read of sbdata0
        access = 3'd1;
        strobe_addr(32'h4002);
        readondata = 1'b1;
        exp_data_q.push_back(32'h0000_BEEF);
        strobe_rdata();
        check("t4b_be",  bus.be, 4'b1100);
        check("t4b_add", bus.add, 32'h4002);
        serve(32'hBEEF_1234, 1'b0, 0);
        check("t4b_inc", sbaddress_out, 32'h4004);
        readondata = 1'b0; autoinc = 1'b0;

        // Grant withheld five cycles, write strobe while busy ignored
        access = 3'd2;
        strobe_addr(32'h2000);
        strobe_wdata(32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_req_%0d", i),   bus.req, 1);
            check($sformatf("t5_add_%0d", i),   bus.add, 32'h2000);
            check($sformatf("t5_be_%0d", i),    bus.be, 4'hF);
            check($sformatf("t5_wdata_%0d", i), bus.wdata, 32'h1234_5678);
            if (i == 2) begin sbdata_in = 32'hFFFF_FFFF; data_wv = 1'b1; end
            tick();
            data_wv = 1'b0;
        end
        serve('0, 1'b0, 0);
        check("t5_idle", sbbusy, 0);
        tick();
        check("t5_no_restart", bus.req, 0);

        // dmactive drop while waiting for a read response
        readonaddr = 1'b1;
        strobe_addr(32'h3000);
        bus.gnt = 1'b1; tick(); bus.gnt = 1'b0;
        dmactive = 1'b0;
        tick();
        check("t6_busy_abort", sbbusy, 1);
        tick(); tick();
        bus.r_valid = 1'b1; bus.r_rdata = 32'hCAFE_F00D; tick(); bus.r_valid = 1'b0;
        check("t6_idle",   sbbusy, 0);
        check("t6_nodata", sbdata_valid, 0);
        check("t6_addr",   sbaddress_out, 0);
        check("t6_data",   sbdata_out, 0);
        dmactive = 1'b1;
        tick();
        check("t6_noreq", bus.req, 0);
        readonaddr = 1'b0;

        // Asynchronous reset during a write request
        strobe_addr(32'h40);
        strobe_wdata(32'hA5A5_A5A5);
        check("t7_req", bus.req, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("t7_req0",   bus.req, 0);
        check("t7_we0",    bus.we, 0);
        check("t7_add0",   bus.add, 0);
        check("t7_wdata0", bus.wdata, 0);
        check("t7_be0",    bus.be, 0);
        check("t7_busy0",  sbbusy, 0);
        check("t7_sbaddr0", sbaddress_out, 0);
        check("t7_err0",   sberr, 0);
        rst_ni = 1'b1;
        tick();
        check("t7_idle", sbbusy, 0);

        check("data_q_left", exp_data_q.size(), 0);
        check("err_q_left",  exp_err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
